// File: rtl/uadder_seq_if.sv
// Start/ready/done handshake bundle for the chunked adder/comparator.
interface uadder_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             cmp;

    modport master (
        output start, abort, op, src_a, src_b,
        input  ready, done, out, cout, cmp
    );

    modport slave (
        input  start, abort, op, src_a, src_b,
        output ready, done, out, cout, cmp
    );
endinterface

// File: rtl/uadder_seq.sv
// Multi-cycle chunked adder/comparator: WADD bits per cycle, LSB first.
module uadder_seq #(
    parameter int WIDTH = 32,
    parameter int WADD  = 12
) (
    input logic         clk,
    input logic         rst,
    uadder_seq_if.slave bus
);
    localparam int NCYC = (WIDTH + WADD - 1) / WADD;
    localparam int WCYC = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int PW   = NCYC * WADD;
    localparam int LW   = WIDTH - (NCYC - 1) * WADD;
    localparam logic [WCYC-1:0] LAST = WCYC'(NCYC - 1);

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_LT  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } adder_op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WCYC-1:0]  cnt;
    adder_op_t        op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic             cmp_q;
    logic             done_q;

    logic             last;
    logic             ready;
    logic             accept;
    logic [31:0]      lo;
    logic [31:0]      cw;
    logic [WADD-1:0]  a_ch;
    logic [WADD-1:0]  b_ch;
    logic [WADD:0]    sum;
    logic [PW-1:0]    mask;
    logic [PW-1:0]    sum_pw;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;
    logic             zero_nxt;
    logic             msb;
    logic             ovf;
    logic             lt;
    logic             cmp_nxt;

    assign last   = (state == RUN) && (cnt == LAST);
    assign ready  = (state == IDLE) || last;
    assign accept = ready && bus.start && !bus.abort;

    // Operands are zero-padded to NCYC*WADD so the top chunk can be
    // sliced uniformly; the mask keeps padding bits out of the result.
    always_comb begin
        lo        = 32'(cnt) * 32'(WADD);
        cw        = last ? 32'(LW) : 32'(WADD);
        a_ch      = WADD'(PW'(a_q) >> lo);
        b_ch      = WADD'(PW'(b_q) >> lo);
        sum       = {1'b0, a_ch} + {1'b0, b_ch} + {{WADD{1'b0}}, carry};
        mask      = {PW{1'b1}} >> (32'(PW) - cw);
        sum_pw    = PW'(sum[WADD-1:0]) & mask;
        carry_nxt = last ? sum[LW] : sum[WADD];
        zero_nxt  = zero && (sum_pw == '0);
        res_nxt   = WIDTH'((PW'(res_q) & ~(mask << lo)) | (sum_pw << lo));
        msb       = res_nxt[WIDTH-1];
        ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (msb != a_q[WIDTH-1]);
        lt        = msb ^ ovf;
        cmp_nxt   = 1'b0;
        unique case (op_q)
            OP_EQ:  cmp_nxt = zero_nxt;
            OP_NE:  cmp_nxt = !zero_nxt;
            OP_LT:  cmp_nxt = lt;
            OP_GE:  cmp_nxt = !lt;
            OP_LTU: cmp_nxt = !carry_nxt;
            OP_GEU: cmp_nxt = carry_nxt;
            OP_ADD: cmp_nxt = 1'b0;
            OP_SUB: cmp_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            out_q  <= '0;
            cout_q <= 1'b0;
            cmp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == RUN && bus.abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                if (state == RUN) begin
                    res_q <= res_nxt;
                    carry <= carry_nxt;
                    zero  <= zero_nxt;
                    cnt   <= cnt + WCYC'(1);
                    if (last) begin
                        out_q  <= res_nxt;
                        cout_q <= carry_nxt;
                        cmp_q  <= cmp_nxt;
                        done_q <= 1'b1;
                        state  <= IDLE;
                        cnt    <= '0;
                    end
                end
                // A start in the final chunk cycle overrides the return to IDLE.
                if (accept) begin
                    op_q  <= adder_op_t'(bus.op);
                    a_q   <= bus.src_a;
                    b_q   <= (bus.op == OP_ADD) ? bus.src_b : ~bus.src_b;
                    carry <= (bus.op != OP_ADD);
                    zero  <= 1'b1;
                    cnt   <= '0;
                    state <= RUN;
                end
            end
        end
    end

    assign bus.ready = ready;
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.cout  = cout_q;
    assign bus.cmp   = cmp_q;
endmodule

// File: tb/tb_uadder_seq.sv
// Randomized and directed bench for uadder_seq against an arithmetic model.
module tb_uadder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [2:0] EQ  = 3'd0;
    localparam logic [2:0] NE  = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] SUB = 3'd3;
    localparam logic [2:0] LT  = 3'd4;
    localparam logic [2:0] GE  = 3'd5;
    localparam logic [2:0] LTU = 3'd6;
    localparam logic [2:0] GEU = 3'd7;

    uadder_seq_if #(.WIDTH(32)) b12 ();
    uadder_seq_if #(.WIDTH(32)) b32 ();

    uadder_seq #(.WIDTH(32), .WADD(12)) u12 (
        .clk (clk),
        .rst (rst),
        .bus (b12)
    );

    uadder_seq #(.WIDTH(32), .WADD(32)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output logic c,
                                  output logic m);
        logic [32:0] s;
        m = 1'b0;
        if (o == ADD) begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
        end else begin
            r = a - b;
            c = (a >= b);
            case (o)
                EQ:      m = (a == b);
                NE:      m = (a != b);
                LT:      m = ($signed(a) < $signed(b));
                GE:      m = ($signed(a) >= $signed(b));
                LTU:     m = (a < b);
                GEU:     m = (a >= b);
                default: m = 1'b0;
            endcase
        end
    endfunction

    function automatic logic rdy(int s);
        return (s == 0) ? b12.ready : b32.ready;
    endfunction

    function automatic logic dn(int s);
        return (s == 0) ? b12.done : b32.done;
    endfunction

    function automatic logic [31:0] q_out(int s);
        return (s == 0) ? b12.out : b32.out;
    endfunction

    function automatic logic q_cout(int s);
        return (s == 0) ? b12.cout : b32.cout;
    endfunction

    function automatic logic q_cmp(int s);
        return (s == 0) ? b12.cmp : b32.cmp;
    endfunction

    task automatic set_in(int s, logic st, logic ab, logic [2:0] o,
                          logic [31:0] a, logic [31:0] b);
        if (s == 0) begin
            b12.start = st;
            b12.abort = ab;
            b12.op    = o;
            b12.src_a = a;
            b12.src_b = b;
        end else begin
            b32.start = st;
            b32.abort = ab;
            b32.op    = o;
            b32.src_a = a;
            b32.src_b = b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in(int s);
        set_in(s, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom);
    endtask

    task automatic run_op(int s, int ncyc, logic [2:0] o,
                          logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        m;
        int          w;
        int          lat;
        int          low;
        model(o, a, b, r, c, m);
        w = 0;
        while (!rdy(s) && w < 20) begin
            tick();
            w++;
        end
        set_in(s, 1'b1, 1'b0, o, a, b);
        tick();
        idle_in(s);
        lat = 0;
        low = 0;
        while (lat < 12 && !dn(s)) begin
            if (!rdy(s)) low++;
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(ncyc));
        chk("ready_low", 64'(low), 64'(ncyc - 1));
        chk("out", 64'(q_out(s)), 64'(r));
        chk("cout", 64'(q_cout(s)), 64'(c));
        chk("cmp", 64'(q_cmp(s)), 64'(m));
        tick();
        chk("done_pulse", 64'(dn(s)), 64'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic count_done(int s, int cycles, output int n,
                              output logic [31:0] last_out);
        n = 0;
        last_out = '0;
        for (int i = 0; i < cycles; i++) begin
            if (dn(s)) begin
                n++;
                last_out = q_out(s);
            end
            tick();
        end
    endtask

    initial begin
        int          n;
        int          lat;
        logic [31:0] lo;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  o;

        set_in(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 64'(b12.ready), 64'h1);
        chk("rst_done", 64'(b12.done), 64'h0);
        chk("rst_out", 64'(b12.out), 64'h0);
        chk("rst_cout", 64'(b12.cout), 64'h0);
        chk("rst_cmp", 64'(b12.cmp), 64'h0);

        run_op(0, 3, ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(0, 3, SUB, 32'h5, 32'h7);
        run_op(0, 3, SUB, 32'h7, 32'h5);
        run_op(0, 3, LT, 32'hFFFF_FFFF, 32'h1);
        run_op(0, 3, GE, 32'hFFFF_FFFF, 32'h1);
        run_op(0, 3, LTU, 32'hFFFF_FFFF, 32'h1);
        run_op(0, 3, GEU, 32'hFFFF_FFFF, 32'h1);
        run_op(0, 3, LT, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op(0, 3, EQ, 32'h1234_5678, 32'h1234_5678);
        run_op(0, 3, NE, 32'h1234_5678, 32'h1234_5679);
        run_op(0, 3, EQ, 32'h1234_5678, 32'h9234_5678);
        run_op(0, 3, NE, 32'h1234_5678, 32'h9234_5678);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            run_op(0, 3, o, a, b);
        end

        // start pulsed mid-run is ignored
        set_in(0, 1'b1, 1'b0, ADD, 32'h10, 32'h20);
        tick();
        idle_in(0);
        tick();
        set_in(0, 1'b1, 1'b0, SUB, 32'h99, 32'h1);
        tick();
        idle_in(0);
        count_done(0, 8, n, lo);
        chk("mid_done_cnt", 64'(n), 64'h1);
        chk("mid_out", 64'(lo), 64'h30);

        // back-to-back issue in the final chunk cycle
        set_in(0, 1'b1, 1'b0, ADD, 32'h0FFF_0FFF, 32'h0001_0001);
        tick();
        idle_in(0);
        tick();
        tick();
        chk("b2b_ready", 64'(b12.ready), 64'h1);
        set_in(0, 1'b1, 1'b0, SUB, 32'h100, 32'h1);
        tick();
        idle_in(0);
        chk("b2b_done1", 64'(b12.done), 64'h1);
        chk("b2b_out1", 64'(b12.out), 64'h1000_1000);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!b12.done && lat < 12);
        chk("b2b_spacing", 64'(lat), 64'h3);
        chk("b2b_out2", 64'(b12.out), 64'hFF);
        chk("b2b_cout2", 64'(b12.cout), 64'h1);
        tick();

        // abort in chunk cycle 1
        run_op(0, 3, ADD, 32'h1111_1111, 32'h2222_2222);
        set_in(0, 1'b1, 1'b0, SUB, 32'h9, 32'h4);
        tick();
        idle_in(0);
        tick();
        set_in(0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);
        tick();
        idle_in(0);
        chk("abort_done", 64'(b12.done), 64'h0);
        chk("abort_ready", 64'(b12.ready), 64'h1);
        chk("abort_out", 64'(b12.out), 64'h3333_3333);
        chk("abort_cout", 64'(b12.cout), 64'h0);
        count_done(0, 6, n, lo);
        chk("abort_no_done", 64'(n), 64'h0);
        run_op(0, 3, SUB, 32'h9, 32'h4);

        // reset in chunk cycle 1
        run_op(0, 3, ADD, 32'hFFFF_FFFF, 32'h2);
        set_in(0, 1'b1, 1'b0, ADD, 32'h5, 32'h6);
        tick();
        idle_in(0);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_out", 64'(b12.out), 64'h0);
        chk("mrst_ready", 64'(b12.ready), 64'h1);
        chk("mrst_done", 64'(b12.done), 64'h0);
        chk("mrst_cout", 64'(b12.cout), 64'h0);
        rst = 1'b0;
        count_done(0, 6, n, lo);
        chk("mrst_no_done", 64'(n), 64'h0);

        // abort together with start while idle
        set_in(0, 1'b1, 1'b1, ADD, 32'h1, 32'h1);
        tick();
        idle_in(0);
        count_done(0, 6, n, lo);
        chk("abst_no_done", 64'(n), 64'h0);
        chk("abst_out", 64'(b12.out), 64'h0);

        // single-cycle configuration
        run_op(1, 1, ADD, 32'h1, 32'h2);
        for (int i = 0; i < 20; i++) begin
            o = 3'($urandom);
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            run_op(1, 1, o, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uadder_seq.md
Name: uadder_seq

Overview:
- Multi-cycle chunked adder/comparator for the micro-coded core. It processes operands WADD bits per cycle, LSB chunk first, with a registered carry between chunks.
- Adds a start/ready/done handshake, operand latching, partial last chunk, branch-compare result, abort, and back-to-back issue.
- Feeds ALU add/sub results and branch decisions to the sequencer.

Parameters:
- WIDTH, 32, operand/result width in bits.
- WADD, 12, chunk width processed per cycle; 1 <= WADD. WADD >= WIDTH gives single-cycle operation.
- NCYC (localparam), ceil(WIDTH/WADD), number of chunk cycles.
- WCYC (localparam), max(1, clog2(NCYC)), chunk counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when ready=1.
- abort  in  1  synchronous cancel of the operation in flight.
- op  in  3  adderOp_t: ADD=010, SUB=011, EQ=000, NE=001, LT=100, GE=101, LTU=110, GEU=111.
- src_a  in  WIDTH  operand A; sampled only on the accepting edge.
- src_b  in  WIDTH  operand B; sampled only on the accepting edge.
- ready  out  1  idle, or completing this cycle; start may be asserted.
- done  out  1  one-cycle pulse; out/cout/cmp valid.
- out  out  WIDTH  A+B for ADD; A-B for all other ops.
- cout  out  1  carry out of bit WIDTH-1 (not-borrow for subtract ops).
- cmp  out  1  compare result for EQ..GEU; 0 for ADD/SUB.

Behaviour:
- Reset values: ready=1, done=0, out=0, cout=0, cmp=0; state IDLE; chunk counter=0; carry=0.
- States:
  - IDLE: ready=1.
  - RUN: ready=0, except on the last chunk cycle.
- Accept: on an edge with ready=1 and start=1, latch op, A and ~B (inverted if op!=ADD), and carry=(op!=ADD), then enter RUN with counter=0.
- start while ready=0 is ignored; no queuing.
- RUN, cycle k (k=0..NCYC-1):
  - Compute chunk k: bits [k*WADD, min((k+1)*WADD, WIDTH)-1] of A + B' + carry.
  - On the next edge, write the chunk into the out register, update carry, and AND the chunk-zero result into the zero flag.
  - The last chunk is WIDTH-(NCYC-1)*WADD bits wide; no bits beyond WIDTH are read or written.
- Completion: on the edge ending chunk NCYC-1:
  - Register cout=final carry.
  - Register cmp per op:
    - EQ: zero
    - NE: !zero
    - LT: out[MSB] ^ ovf, where ovf = (a[MSB]==~b[MSB]) & (out[MSB]!=a[MSB])
    - GE: !LT
    - LTU: !cout
    - GEU: cout
    - ADD/SUB: 0
  - Assert done for exactly the following cycle.
- Latency: accept edge E0 -> done high in the cycle after edge E_NCYC.
  - NCYC=3: done in the 3rd cycle after E0.
  - NCYC=1: done in the 1st cycle after E0.
- Back-to-back: ready=1 in the final RUN cycle, so a start there is accepted on the completion edge. Throughput is one op per NCYC cycles.
- out/cout/cmp hold their values from done until the edge after the next accepted start; partial results are not guaranteed outside done.
- abort=1 in RUN: return to IDLE on that edge, no done, and out/cout/cmp keep their previous completed values. abort in IDLE has no effect.
- abort and start in the same ready cycle: abort wins and nothing is accepted.
- rst has priority over everything; rst mid-operation returns all outputs to their reset values with no done.
- Arithmetic is modulo 2^WIDTH; no sign extension beyond WIDTH.

Test Plan:
- WIDTH=32, WADD=12: ADD 0xFFFFFFFF + 0x00000001 -> done 3 cycles after accept; out=0x00000000, cout=1, cmp=0; ready low for exactly 2 cycles.
- SUB 5-7 -> out=0xFFFFFFFE, cout=0. SUB 7-5 -> out=0x00000002, cout=1.
- A=0xFFFFFFFF, B=0x00000001:
  - LT -> cmp=1; GE -> cmp=0.
  - LTU -> cmp=0; GEU -> cmp=1.
  - A=0x80000000, B=0x7FFFFFFF, LT -> cmp=1 (overflow case).
- EQ 0x12345678 vs 0x12345678 -> cmp=1. NE with B=0x12345679 -> cmp=1. Differing only in bit 31 (top, partial chunk) -> EQ cmp=0.
- Back-to-back start in the final RUN cycle -> second done exactly 3 cycles after the first. start pulsed mid-RUN -> ignored, no extra done.
- abort in chunk cycle 1 -> no done, out unchanged, ready=1 next cycle.
- rst in chunk cycle 1 -> out=0, ready=1, done never asserts.
- WIDTH=32, WADD=32: ADD 1+2 -> done the cycle after accept, out=3.
